// File: rtl/spio_spinnaker_link_flit_arbiter.sv
// Round-robin packet arbiter that shares one SpiNNaker link transmitter.
// Each grant is held for a whole packet, which ends on the EOP flit.
module spio_spinnaker_link_flit_arbiter #(
   parameter int         NUM_PORTS   = 2,
   parameter logic [6:0] EOP_CODE    = 7'h60,
   parameter int         STALL_LIMIT = 1024
) (
   input  logic                   CLK_IN,
   input  logic                   RESET_IN,
   input  logic [7*NUM_PORTS-1:0] IN_DATA_2OF7,
   input  logic [NUM_PORTS-1:0]   IN_VLD,
   output logic [NUM_PORTS-1:0]   IN_RDY,
   output logic [6:0]             flt_data_2of7,
   output logic                   flt_vld,
   input  logic                   flt_rdy,
   input  logic                   ENABLE_IN,
   output logic [NUM_PORTS-1:0]   GRANT_OUT,
   output logic                   BUSY_OUT,
   output logic                   STALL_OUT
);

   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q;
   logic [IW-1:0]        last_q;
   logic [IW-1:0]        gidx_q;
   logic [NUM_PORTS-1:0] grant_q;
   logic [6:0]           data_q;
   logic                 vld_q;
   logic [15:0]          cnt_q;
   logic [15:0]          cnt_d;
   logic                 stall_q;

   logic [IW-1:0]        pick_idx;
   logic [IW-1:0]        cand;
   logic                 pick_vld;
   logic [6:0]           acc_data;
   logic                 acc;

   // Walk downwards so the port nearest after last_q wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = IW'((int'(last_q) + k) % NUM_PORTS);
         if (IN_VLD[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      acc_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q[i]) acc_data = IN_DATA_2OF7[7*i +: 7];
      end
   end

   assign IN_RDY = grant_q & {NUM_PORTS{~vld_q | flt_rdy}};
   assign acc    = |(IN_VLD & IN_RDY);

   always_comb begin
      cnt_d = cnt_q;
      if (!vld_q || flt_rdy)
         cnt_d = '0;
      else if (cnt_q != LIMIT)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         state_q <= IDLE;
         last_q  <= IW'(NUM_PORTS - 1);
         gidx_q  <= '0;
         grant_q <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ENABLE_IN && pick_vld) begin
                  state_q <= LOCKED;
                  gidx_q  <= pick_idx;
                  grant_q <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
               end
            end
            LOCKED: begin
               if (acc && acc_data == EOP_CODE) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  last_q  <= gidx_q;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (acc) begin
            data_q <= acc_data;
            vld_q  <= 1'b1;
         end else if (flt_rdy) begin
            vld_q  <= 1'b0;
         end

         cnt_q   <= cnt_d;
         stall_q <= (cnt_q == LIMIT);
      end
   end

   assign flt_data_2of7 = data_q;
   assign flt_vld       = vld_q;
   assign GRANT_OUT     = grant_q;
   assign BUSY_OUT      = (state_q == LOCKED) | vld_q;
   assign STALL_OUT     = stall_q;

endmodule

// File: tb/tb_spio_spinnaker_link_flit_arbiter.sv
// Directed bench for the link flit arbiter: two ports, STALL_LIMIT=8.
// Upstream serializers are modelled as flit queues popped on handshake.
module tb_spio_spinnaker_link_flit_arbiter;

   localparam int NP = 2;

   logic          CLK_IN = 1'b0;
   logic          RESET_IN;
   logic [7*NP-1:0] IN_DATA_2OF7;
   logic [NP-1:0] IN_VLD;
   logic [NP-1:0] IN_RDY;
   logic [6:0]    flt_data_2of7;
   logic          flt_vld;
   logic          flt_rdy;
   logic          ENABLE_IN;
   logic [NP-1:0] GRANT_OUT;
   logic          BUSY_OUT;
   logic          STALL_OUT;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] q0[$];
   logic [6:0] q1[$];
   logic [6:0] outlog[$];
   logic [6:0] exp_q[$];
   logic [NP-1:0] gl[12];
   logic [NP-1:0] exp_g[12];

   spio_spinnaker_link_flit_arbiter #(
      .NUM_PORTS(NP), .EOP_CODE(7'h60), .STALL_LIMIT(8)
   ) dut (
      .CLK_IN(CLK_IN), .RESET_IN(RESET_IN),
      .IN_DATA_2OF7(IN_DATA_2OF7), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
      .flt_data_2of7(flt_data_2of7), .flt_vld(flt_vld), .flt_rdy(flt_rdy),
      .ENABLE_IN(ENABLE_IN), .GRANT_OUT(GRANT_OUT),
      .BUSY_OUT(BUSY_OUT), .STALL_OUT(STALL_OUT)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      IN_VLD[0]          = (q0.size() != 0);
      IN_VLD[1]          = (q1.size() != 0);
      IN_DATA_2OF7[6:0]  = (q0.size() != 0) ? q0[0] : 7'h0;
      IN_DATA_2OF7[13:7] = (q1.size() != 0) ? q1[0] : 7'h0;
   endtask

   // Sample handshakes with pre-edge values, then update stimulus.
   task automatic step();
      logic [NP-1:0] tk;
      logic          ot;
      logic [6:0]    od;
      @(posedge CLK_IN);
      tk = IN_VLD & IN_RDY;
      ot = flt_vld & flt_rdy;
      od = flt_data_2of7;
      #1;
      if (ot) outlog.push_back(od);
      if (tk[0]) void'(q0.pop_front());
      if (tk[1]) void'(q1.pop_front());
      drive();
   endtask

   task automatic do_reset();
      RESET_IN = 1'b1;
      q0.delete();
      q1.delete();
      outlog.delete();
      drive();
      repeat (2) step();
      RESET_IN = 1'b0;
   endtask

   task automatic chk_log(input string tag);
      chk({tag, "_n"}, 32'(outlog.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk(tag, (i < outlog.size()) ? 32'(outlog[i]) : 32'hffff,
             32'(exp_q[i]));
   endtask

   initial begin
      RESET_IN     = 1'b1;
      IN_VLD       = '0;
      IN_DATA_2OF7 = '0;
      flt_rdy      = 1'b1;
      ENABLE_IN    = 1'b1;
      repeat (2) step();
      chk("rst_vld", flt_vld, 0);
      chk("rst_data", flt_data_2of7, 0);
      chk("rst_grant", GRANT_OUT, 0);
      chk("rst_stall", STALL_OUT, 0);
      chk("rst_busy", BUSY_OUT, 0);
      chk("rst_rdy", IN_RDY, 0);
      RESET_IN = 1'b0;

      // single port, 3-flit packet
      q0 = '{7'h11, 7'h12, 7'h60};
      drive();
      step();
      chk("t1_grant", GRANT_OUT, 2'b01);
      chk("t1_rdy", IN_RDY, 2'b01);
      chk("t1_vld0", flt_vld, 0);
      step();
      chk("t1_d0", flt_data_2of7, 7'h11);
      chk("t1_vld1", flt_vld, 1);
      step();
      chk("t1_d1", flt_data_2of7, 7'h12);
      step();
      chk("t1_d2", flt_data_2of7, 7'h60);
      chk("t1_gnt_eop", GRANT_OUT, 0);
      chk("t1_busy", BUSY_OUT, 1);
      step();
      chk("t1_vld_end", flt_vld, 0);
      chk("t1_busy_end", BUSY_OUT, 0);
      exp_q = '{7'h11, 7'h12, 7'h60};
      chk_log("t1_log");

      // two ports from reset, continuous requests
      do_reset();
      q0 = '{7'h0A, 7'h60, 7'h0B, 7'h60};
      q1 = '{7'h2A, 7'h60, 7'h2B, 7'h60};
      drive();
      exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
      for (int s = 0; s < 12; s++) begin
         step();
         gl[s] = GRANT_OUT;
      end
      step();
      for (int s = 0; s < 12; s++) chk("t2_grant", gl[s], exp_g[s]);
      exp_q = '{7'h0A, 7'h60, 7'h2A, 7'h60, 7'h0B, 7'h60, 7'h2B, 7'h60};
      chk_log("t2_log");

      // backpressure mid-packet
      outlog.delete();
      q0 = '{7'h31, 7'h32, 7'h33, 7'h60};
      drive();
      repeat (3) step();
      flt_rdy = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("t3_hold", flt_data_2of7, 7'h32);
         chk("t3_vld", flt_vld, 1);
         chk("t3_rdy", IN_RDY, 0);
      end
      flt_rdy = 1'b1;
      repeat (4) step();
      exp_q = '{7'h31, 7'h32, 7'h33, 7'h60};
      chk_log("t3_log");

      // stall watchdog
      outlog.delete();
      q0 = '{7'h41, 7'h60};
      drive();
      step();
      flt_rdy = 1'b0;
      step();
      chk("t4_d", flt_data_2of7, 7'h41);
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("t4_stall", STALL_OUT, (k >= 9) ? 1 : 0);
      end
      flt_rdy = 1'b1;
      step();
      chk("t4_stall_xfer", STALL_OUT, 1);
      step();
      chk("t4_stall_clr", STALL_OUT, 0);
      step();
      exp_q = '{7'h41, 7'h60};
      chk_log("t4_log");

      // ENABLE_IN dropped mid-packet
      outlog.delete();
      q1 = '{7'h51, 7'h52, 7'h60};
      drive();
      step();
      chk("t5_grant1", GRANT_OUT, 2'b10);
      step();
      ENABLE_IN = 1'b0;
      q0 = '{7'h71, 7'h60};
      drive();
      repeat (2) step();
      for (int s = 0; s < 3; s++) begin
         step();
         chk("t5_nogrant", GRANT_OUT, 0);
      end
      exp_q = '{7'h51, 7'h52, 7'h60};
      chk_log("t5_log1");
      ENABLE_IN = 1'b1;
      step();
      chk("t5_grant0", GRANT_OUT, 2'b01);
      repeat (4) step();
      exp_q = '{7'h51, 7'h52, 7'h60, 7'h71, 7'h60};
      chk_log("t5_log2");

      // reset while locked with a stalled flit
      q0 = '{7'h61, 7'h62, 7'h60};
      drive();
      step();
      flt_rdy = 1'b0;
      step();
      repeat (10) step();
      chk("t6_stall_pre", STALL_OUT, 1);
      chk("t6_vld_pre", flt_vld, 1);
      RESET_IN = 1'b1;
      #1;
      chk("t6_vld", flt_vld, 0);
      chk("t6_grant", GRANT_OUT, 0);
      chk("t6_stall", STALL_OUT, 0);
      chk("t6_busy", BUSY_OUT, 0);
      q0.delete();
      q1.delete();
      outlog.delete();
      drive();
      flt_rdy = 1'b1;
      repeat (2) step();
      RESET_IN = 1'b0;
      q0 = '{7'h05, 7'h60};
      q1 = '{7'h2C, 7'h60};
      drive();
      step();
      chk("t6_first", GRANT_OUT, 2'b01);
      repeat (8) step();
      exp_q = '{7'h05, 7'h60, 7'h2C, 7'h60};
      chk_log("t6_log");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spio_spinnaker_link_flit_arbiter.md
Name: spio_spinnaker_link_flit_arbiter

Overview:
- Packet-level arbiter that shares one SpiNNaker link transmitter (2-of-7 flit stream into the sync-to-async FIFO) between NUM_PORTS packet serializers.
- Grants the link round-robin at packet boundaries and holds the grant until the granted port's EOP flit is transferred, so flits of different packets never interleave.
- Drives a registered single-flit output stage, and includes a stall watchdog for a link that stops acknowledging.

Parameters:
- NUM_PORTS, 2, number of requesting serializers (2..8).
- EOP_CODE, 7'h60, 2-of-7 end-of-packet symbol.
- STALL_LIMIT, 1024, consecutive stalled cycles before STALL_OUT asserts (STALL_LIMIT < 2^16).

Ports:
- CLK_IN  in  1  system clock
- RESET_IN  in  1  asynchronous, active-high reset
- IN_DATA_2OF7  in  7*NUM_PORTS  per-port flit; port i occupies bits [7i+6:7i]
- IN_VLD  in  NUM_PORTS  per-port flit valid
- IN_RDY  out  NUM_PORTS  per-port flit ready
- flt_data_2of7  out  7  flit to FIFO
- flt_vld  out  1  flit valid to FIFO
- flt_rdy  in  1  FIFO ready (registered in FIFO)
- ENABLE_IN  in  1  allow new packet grants
- GRANT_OUT  out  NUM_PORTS  one-hot current grant, zero in IDLE
- BUSY_OUT  out  1  1 when LOCKED or flt_vld=1
- STALL_OUT  out  1  watchdog flag

Behaviour:
- Clock and reset: CLK_IN, with RESET_IN asynchronous, active-high.
- Reset values:
  - flt_vld=0, flt_data_2of7=0, GRANT_OUT=0, STALL_OUT=0, state=IDLE.
  - Round-robin pointer last=NUM_PORTS-1, so port 0 has first priority.
  - Stall counter=0.
- Handshake:
  - Output transfer when flt_vld&&flt_rdy.
  - Input transfer on port i when IN_VLD[i]&&IN_RDY[i].
- IN_RDY[i] = GRANT_OUT[i] && (~flt_vld || flt_rdy). This is combinational, and all non-granted bits are 0.
- Output register:
  - On an input transfer, load flt_data_2of7 with the port flit and set flt_vld=1.
  - On an output transfer with no input transfer, clear flt_vld.
  - Sustains 1 flit/cycle within a packet.
- IDLE state:
  - If ENABLE_IN=1 and IN_VLD!=0, grant the first port with IN_VLD set, searching last+1, last+2, ... modulo NUM_PORTS.
  - Set GRANT_OUT one-hot and go to LOCKED at the next edge.
  - No input is accepted in IDLE, which gives a 1-cycle arbitration bubble per packet.
- LOCKED state:
  - Accept flits from the granted port only.
  - If the granted IN_VLD drops mid-packet, stay LOCKED and wait; there is no timeout and no abort.
- Packet end: when the accepted flit equals EOP_CODE, on the same edge:
  - state←IDLE, GRANT_OUT←0, last←granted index.
  - The EOP flit is still loaded into the output register.
- ENABLE_IN:
  - Only gates new grants in IDLE.
  - Deasserting it mid-packet does not truncate the packet.
  - Pending output flits still drain.
- Fairness: with all ports continuously requesting, grants rotate 0,1,..,N-1,0. No port waits more than NUM_PORTS-1 packets.
- Stall watchdog:
  - 16-bit counter increments on each cycle with flt_vld&&~flt_rdy, saturating at STALL_LIMIT.
  - Cleared on any output transfer or when flt_vld=0.
  - STALL_OUT = (counter==STALL_LIMIT), registered.
  - Status only; no effect on the datapath.
- Reset mid-packet: all state cleared immediately, and the in-flight output flit is discarded (flt_vld→0 asynchronously). Upstream serializers are reset by the same RESET_IN.
- A non-granted IN_VLD never affects the datapath. A flit arriving at the granted port in the same cycle as the grant is accepted the cycle after the grant is asserted.

Test Plan:
- Single port: port 0 sends 3-flit packet 7'h11,7'h12,7'h60 with flt_rdy=1.
  - GRANT_OUT=01 the cycle after IN_VLD.
  - flt_data_2of7 shows 11,12,60 on consecutive cycles.
  - GRANT_OUT=00 after EOP; total 5 cycles from request to flt_vld=0.
- Two ports request simultaneously from reset, each sending 2-flit packets ending 7'h60, both re-requesting continuously.
  - Packet order is port0, port1, port0, port1.
  - No interleaved flits; one bubble cycle between packets.
- Backpressure: hold flt_rdy=0 for 5 cycles mid-packet.
  - flt_data_2of7 stable, IN_RDY[granted]=0 throughout.
  - No flit lost or duplicated after release.
- Watchdog with STALL_LIMIT=8: flt_vld=1, flt_rdy=0 for 10 cycles.
  - STALL_OUT rises after the 8th stalled cycle (registered, +1) and stays high.
  - Clears the cycle after the first output transfer.
- ENABLE_IN dropped mid-packet on port 1, then port 0 requests.
  - Port 1 packet completes through EOP.
  - Port 0 is not granted until ENABLE_IN returns to 1.
- Assert RESET_IN while LOCKED with flt_vld=1.
  - flt_vld, GRANT_OUT, STALL_OUT → 0 immediately.
  - After release, port 0 wins first arbitration.
